// File: rtl/alu_pkg.sv
// Shared ALU control codes, MULTU/DIVU op encodings and the sequencer state type.
package alu_pkg;

    localparam int MD_XLEN   = 32;
    localparam int MD_ITER_W = 5;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_PASS = 5'b00111;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b01110;
    localparam logic [4:0] ALU_SRA  = 5'b01111;
    localparam logic [4:0] ALU_SLT  = 5'b10000;

    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the issuing pipeline and the MULTU/DIVU sequencer.
interface muldiv_seq_if;
    import alu_pkg::*;

    logic               start;
    logic               op;
    logic [MD_XLEN-1:0] rs_val;
    logic [MD_XLEN-1:0] rt_val;
    logic               stall;
    logic               done;
    logic [MD_XLEN-1:0] hi;
    logic [MD_XLEN-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output stall, done, hi, lo
    );

endinterface

// File: rtl/alu_port_mux.sv
// Ownership mux for the shared execution-stage ALU inputs.
module alu_port_mux
    import alu_pkg::*;
(
    input  logic               own,
    input  logic [4:0]         seq_aluctrl,
    input  logic [MD_XLEN-1:0] seq_d1,
    input  logic [MD_XLEN-1:0] seq_d2,
    input  logic [4:0]         ex_aluctrl,
    input  logic [MD_XLEN-1:0] ex_d1,
    input  logic [MD_XLEN-1:0] ex_d2,
    output logic [4:0]         alu_aluctrl,
    output logic [MD_XLEN-1:0] alu_d1,
    output logic [MD_XLEN-1:0] alu_d2
);

    assign alu_aluctrl = own ? seq_aluctrl : ex_aluctrl;
    assign alu_d1      = own ? seq_d1      : ex_d1;
    assign alu_d2      = own ? seq_d2      : ex_d2;

endmodule

// File: rtl/muldiv_seq.sv
// MULTU/DIVU sequencer: 32 iterations of the shared ALU, result in HI/LO.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN   = MD_XLEN,
    parameter int ITER_W = MD_ITER_W
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_seq_if.slave     bus,
    input  logic [4:0]      ex_aluctrl,
    input  logic [XLEN-1:0] ex_d1,
    input  logic [XLEN-1:0] ex_d2,
    output logic [4:0]      alu_aluctrl,
    output logic [XLEN-1:0] alu_d1,
    output logic [XLEN-1:0] alu_d2,
    input  logic [XLEN-1:0] alu_result
);

    md_state_t         state, state_n;
    logic [XLEN-1:0]   hi_q, hi_n;
    logic [XLEN-1:0]   lo_q, lo_n;
    logic [XLEN-1:0]   opnd_q, opnd_n;
    logic              op_q, op_n;
    logic [ITER_W-1:0] count_q, count_n;

    logic [4:0]      seq_aluctrl;
    logic [XLEN-1:0] seq_d1, seq_d2;
    logic [XLEN-1:0] rem;
    logic            carry, take;

    // opnd holds the multiplicand for MULTU and the divisor for DIVU
    always_comb begin
        rem   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        carry = lo_q[0] & (alu_result < hi_q);
        take  = hi_q[XLEN-1] | (rem >= opnd_q);
        seq_aluctrl = ALU_PASS;
        seq_d1      = '0;
        seq_d2      = hi_q;
        if (op_q == MD_DIVU) begin
            seq_aluctrl = ALU_SUB;
            seq_d1      = rem;
            seq_d2      = opnd_q;
        end else if (lo_q[0]) begin
            seq_aluctrl = ALU_ADD;
            seq_d1      = hi_q;
            seq_d2      = opnd_q;
        end
    end

    always_comb begin
        state_n = state;
        hi_n    = hi_q;
        lo_n    = lo_q;
        opnd_n  = opnd_q;
        op_n    = op_q;
        count_n = count_q;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    op_n    = bus.op;
                    count_n = '0;
                    if (bus.op == MD_DIVU && bus.rt_val == '0) begin
                        hi_n    = bus.rs_val;
                        lo_n    = '1;
                        state_n = ST_DONE;
                    end else if (bus.op == MD_DIVU) begin
                        hi_n    = '0;
                        lo_n    = bus.rs_val;
                        opnd_n  = bus.rt_val;
                        state_n = ST_RUN;
                    end else begin
                        hi_n    = '0;
                        lo_n    = bus.rt_val;
                        opnd_n  = bus.rs_val;
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                count_n = count_q + 1'b1;
                if (op_q == MD_DIVU) begin
                    hi_n = take ? alu_result : rem;
                    lo_n = {lo_q[XLEN-2:0], take};
                end else begin
                    hi_n = {carry, alu_result[XLEN-1:1]};
                    lo_n = {alu_result[0], lo_q[XLEN-1:1]};
                end
                if (count_q == '1)
                    state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            op_q    <= MD_MULTU;
            count_q <= '0;
        end else begin
            state   <= state_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            opnd_q  <= opnd_n;
            op_q    <= op_n;
            count_q <= count_n;
        end
    end

    assign bus.stall = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    alu_port_mux u_mux (
        .own         (state == ST_RUN),
        .seq_aluctrl (seq_aluctrl),
        .seq_d1      (seq_d1),
        .seq_d2      (seq_d2),
        .ex_aluctrl  (ex_aluctrl),
        .ex_d1       (ex_d1),
        .ex_d2       (ex_d2),
        .alu_aluctrl (alu_aluctrl),
        .alu_d1      (alu_d1),
        .alu_d2      (alu_d2)
    );

endmodule
